axis_to_mii_tx: RTL and testbench
=================================

Name: axis_to_mii_tx

Overview:
Parametrised AXI-Stream-to-MII/RMII transmit serialiser. It is the next generation of the fixed 2-bit TX block.
- Byte stream in, one W-bit symbol per clock out, LSB-first.
- Width is selectable (RMII di-bit or MII nibble).
- Optional automatic preamble/SFD insertion and a configurable inter-frame gap.
- Underrun detection with TX_ER signalling and discard of the rest of the frame.
- Sits between the MAC frame builder (FCS already appended upstream) and the PHY pins.

Parameters:
- SYMBOL_WIDTH, 2, bits per clock on tx_d. Legal values are 2 (RMII) and 4 (MII); anything else is an elaboration error.
- PREAMBLE_EN, 1, when 1, 7×0x55 plus 0xD5 is emitted before each frame's first payload byte.
- IFG_BYTES, 12, minimum idle gap after each frame, in byte times.
- IFG_CNT_WIDTH, 8, width of the gap counter. It must hold IFG_BYTES*(8/SYMBOL_WIDTH).

Ports:
- clock  in  1  single clock; PHY reference clock domain.
- reset  in  1  synchronous, active-high.
- tx_d  out  SYMBOL_WIDTH  PHY transmit data, registered.
- tx_en  out  1  PHY transmit enable, registered.
- tx_er  out  1  PHY transmit error, registered. Left unconnected for RMII.
- saxis_tdata  in  8  frame byte.
- saxis_tvalid  in  1
- saxis_tready  out  1  combinational from state.
- saxis_tlast  in  1  last byte of frame.
- underrun  out  1  one-cycle pulse when an underrun is detected.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Definitions:
  - S = 8/SYMBOL_WIDTH symbol cycles per byte.
  - phase is a counter 0..S-1.
  - cur_byte and cur_last hold the byte currently being shifted out.
- Reset:
  - state = IDLE, phase = 0.
  - tx_d = 0, tx_en = 0, tx_er = 0, underrun = 0.
  - cur_last = 0; ifg counter = 0.
  - Reset mid-frame aborts immediately: tx_en drops on the cycle after reset is sampled, with no TX_ER and no drain.
- States:
  - IDLE
  - PREAMBLE
  - DATA
  - ERR
  - DISCARD
  - IFG
- IDLE:
  - PREAMBLE_EN=1: saxis_tready=0. On tvalid, go to PREAMBLE with phase=0 and preamble byte index 0. The first preamble symbol appears on tx_d/tx_en in the next cycle, so latency from tvalid to tx_en is 1 cycle.
  - PREAMBLE_EN=0: saxis_tready=1. On handshake, latch tdata/tlast and go to DATA. tx_en rises 1 cycle later.
- PREAMBLE:
  - Outputs bytes 0x55 ×7 then 0xD5, LSB-first: tx_en=1, tx_er=0.
  - On the final symbol of 0xD5, saxis_tready=1. If tvalid, latch and go to DATA; otherwise underrun.
- DATA:
  - Outputs symbol cur_byte[phase*W +: W] with tx_en=1.
  - On phase=S-1, the cycle ends in one of three ways:
    - cur_last=1: tready=0, go to IFG.
    - cur_last=0 and tvalid: tready=1, latch, phase=0, stay in DATA with back-to-back bytes and no bubble.
    - cur_last=0 and !tvalid: underrun.
- Underrun:
  - Pulse underrun for 1 cycle and go to ERR.
  - ERR drives tx_en=1, tx_er=1, tx_d=0 for S cycles (one errored byte time).
  - It then goes to DISCARD.
- DISCARD:
  - tx_en=0, saxis_tready=1.
  - Beats are consumed and dropped until a beat with tlast=1 is accepted, then go to IFG.
  - If the underrun occurred while fetching a byte that is not yet present, the frame remainder is still discarded by this rule.
- IFG:
  - tx_en=0, tx_er=0, tready=0 for exactly IFG_BYTES*S cycles, counted from the first cycle with tx_en=0. Then go to IDLE.
- tx_d is driven to 0 whenever tx_en=0.
- saxis_tready is never asserted in ERR or IFG.

Decomposition:
- Package mii_pkg:
  - state_t enum.
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7.
  - Function symbols_per_byte(width).
- Sub-module mii_byte_serializer: holds byte register, phase counter and symbol mux, with load/advance/last_phase handshake. It is reused by the future RX-side loopback checker.
- The top level holds the FSM, IFG counter and underrun logic.

Test Plan:
1. W=2, PREAMBLE_EN=0, IFG=12: a single byte 0xB4 with tlast -> tx_d sequence 0,1,3,2 with tx_en=1 for 4 cycles, then tx_en=0 for 48 cycles; busy falls on cycle 53.
2. W=4, PREAMBLE_EN=1: frame 0x12,0x34 continuously valid -> 16 symbols 5,5,…,5,D, then 2,1,4,3. tx_en is high for exactly 20 cycles with no gap between preamble and payload.
3. W=2, back-to-back stream 0x00..0x3F with tlast on 0x3F -> 256 contiguous tx_en cycles. tready is high once every 4 cycles and never in IFG. Bytes are reassembled identically.
4. Underrun: W=4, tvalid dropped after byte 3 of a 10-byte frame.
   - underrun pulses once.
   - 2 cycles of tx_en=1/tx_er=1 follow.
   - The 6 remaining beats are accepted and dropped; nothing is emitted.
   - 24 IFG cycles follow.
   - The next frame transmits correctly.
5. Reset asserted for 1 cycle mid-payload -> the next cycle shows tx_en=0, tx_er=0, tx_d=0, busy=0, tready reflects IDLE. A new frame starts cleanly.
6. Two frames offered back-to-back, W=2, IFG_BYTES=3 -> exactly 12 idle cycles between the last tx_en of frame 1 and the first of frame 2.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared types and constants for the MII/RMII transmit datapath.
// Imported by the serializer, the transmit top level and their benches.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_ERR      = 3'd3,
    ST_DISCARD  = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;

  function automatic int symbols_per_byte(input int width);
    return 8 / width;
  endfunction

endpackage

// File: rtl/axis_to_mii_tx_if.sv
// Byte-wide AXI-Stream bundle feeding the MII/RMII transmitter.
// The frame source drives the master side, the transmitter takes the slave side.
interface axis_to_mii_tx_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/mii_byte_serializer.sv
// Holds one byte and walks it out LSB-first, SYMBOL_WIDTH bits per advance.
// sym_d_o is the symbol selected after this cycle's load/advance, for a registered pin stage.
module mii_byte_serializer
  import mii_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [7:0]              byte_i,
  input  logic                    advance_i,
  output logic                    last_phase_o,
  output logic [SYMBOL_WIDTH-1:0] sym_d_o
);

  localparam int S  = symbols_per_byte(SYMBOL_WIDTH);
  localparam int PW = $clog2(S);

  logic [7:0]    byte_q, byte_d;
  logic [PW-1:0] phase_q, phase_d;

  assign last_phase_o = (phase_q == PW'(S - 1));

  always_comb begin
    byte_d  = byte_q;
    phase_d = phase_q;
    if (load_i) begin
      byte_d  = byte_i;
      phase_d = '0;
    end else if (advance_i) begin
      phase_d = last_phase_o ? '0 : phase_q + 1'b1;
    end
  end

  assign sym_d_o = byte_d[phase_d*SYMBOL_WIDTH +: SYMBOL_WIDTH];

  always_ff @(posedge clock) begin
    byte_q <= byte_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/axis_to_mii_tx.sv
// AXI-Stream to MII/RMII transmit serialiser: preamble/SFD insertion, inter-frame gap,
// and underrun handling (one errored byte time, then drop the rest of the frame).
module axis_to_mii_tx
  import mii_pkg::*;
#(
  parameter int SYMBOL_WIDTH  = 2,
  parameter bit PREAMBLE_EN   = 1'b1,
  parameter int IFG_BYTES     = 12,
  parameter int IFG_CNT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  axis_to_mii_tx_if.slave         saxis,
  output logic [SYMBOL_WIDTH-1:0] tx_d,
  output logic                    tx_en,
  output logic                    tx_er,
  output logic                    underrun,
  output logic                    busy
);

  if (SYMBOL_WIDTH != 2 && SYMBOL_WIDTH != 4) begin : g_bad_width
    $error("axis_to_mii_tx: SYMBOL_WIDTH must be 2 or 4");
  end

  localparam int S         = symbols_per_byte(SYMBOL_WIDTH);
  localparam int IFG_TOTAL = IFG_BYTES * S;

  if (IFG_TOTAL > (2 ** IFG_CNT_WIDTH) - 1) begin : g_bad_ifg
    $error("axis_to_mii_tx: IFG_CNT_WIDTH too small for IFG_BYTES");
  end

  localparam logic [IFG_CNT_WIDTH-1:0] IFG_LOAD  = IFG_CNT_WIDTH'(IFG_TOTAL - 1);
  localparam logic [2:0]               SFD_IDX   = 3'(PREAMBLE_LEN);
  localparam state_t                   GAP_STATE = (IFG_TOTAL > 0) ? ST_IFG : ST_IDLE;

  state_t                   state_q, state_d;
  logic [2:0]               pre_idx_q, pre_idx_d;
  logic                     cur_last_q, cur_last_d;
  logic [IFG_CNT_WIDTH-1:0] ifg_q, ifg_d;
  logic [SYMBOL_WIDTH-1:0]  tx_d_q, tx_d_d;
  logic                     tx_en_q, tx_en_d;
  logic                     tx_er_q, tx_er_d;
  logic                     underrun_q, underrun_d;

  logic                     ser_load, ser_adv, ser_last;
  logic [7:0]               ser_byte;
  logic [SYMBOL_WIDTH-1:0]  ser_sym;
  logic                     tready_c;

  mii_byte_serializer #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH)
  ) u_ser (
    .clock        (clock),
    .reset        (reset),
    .load_i       (ser_load),
    .byte_i       (ser_byte),
    .advance_i    (ser_adv),
    .last_phase_o (ser_last),
    .sym_d_o      (ser_sym)
  );

  // State reflects what is on the pins this cycle; pin registers load from the next state.
  always_comb begin
    state_d    = state_q;
    pre_idx_d  = pre_idx_q;
    cur_last_d = cur_last_q;
    ifg_d      = ifg_q;
    ser_load   = 1'b0;
    ser_byte   = PREAMBLE_BYTE;
    ser_adv    = 1'b0;
    tready_c   = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PREAMBLE_EN) begin
          if (saxis.tvalid) begin
            state_d   = ST_PREAMBLE;
            pre_idx_d = '0;
            ser_load  = 1'b1;
          end
        end else begin
          tready_c = 1'b1;
          if (saxis.tvalid) begin
            state_d    = ST_DATA;
            ser_load   = 1'b1;
            ser_byte   = saxis.tdata;
            cur_last_d = saxis.tlast;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!ser_last) begin
          ser_adv = 1'b1;
        end else if (pre_idx_q != SFD_IDX) begin
          pre_idx_d = pre_idx_q + 3'd1;
          ser_load  = 1'b1;
          ser_byte  = (pre_idx_q == SFD_IDX - 3'd1) ? SFD_BYTE : PREAMBLE_BYTE;
        end else begin
          tready_c = 1'b1;
          if (saxis.tvalid) begin
            state_d    = ST_DATA;
            ser_load   = 1'b1;
            ser_byte   = saxis.tdata;
            cur_last_d = saxis.tlast;
          end else begin
            state_d    = ST_ERR;
            underrun_d = 1'b1;
            ser_load   = 1'b1;
            ser_byte   = 8'h00;
          end
        end
      end
      ST_DATA: begin
        if (!ser_last) begin
          ser_adv = 1'b1;
        end else if (cur_last_q) begin
          state_d = GAP_STATE;
          ifg_d   = IFG_LOAD;
        end else begin
          tready_c = 1'b1;
          if (saxis.tvalid) begin
            ser_load   = 1'b1;
            ser_byte   = saxis.tdata;
            cur_last_d = saxis.tlast;
          end else begin
            state_d    = ST_ERR;
            underrun_d = 1'b1;
            ser_load   = 1'b1;
            ser_byte   = 8'h00;
          end
        end
      end
      ST_ERR: begin
        if (!ser_last) begin
          ser_adv = 1'b1;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        tready_c = 1'b1;
        if (saxis.tvalid && saxis.tlast) begin
          state_d = GAP_STATE;
          ifg_d   = IFG_LOAD;
        end
      end
      ST_IFG: begin
        // A frame already waiting starts its preamble straight out of the gap, keeping the gap exact.
        if (ifg_q != '0) begin
          ifg_d = ifg_q - 1'b1;
        end else if (PREAMBLE_EN && saxis.tvalid) begin
          state_d   = ST_PREAMBLE;
          pre_idx_d = '0;
          ser_load  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_en_d = (state_d == ST_PREAMBLE) || (state_d == ST_DATA) || (state_d == ST_ERR);
    tx_er_d = (state_d == ST_ERR);
    tx_d_d  = ((state_d == ST_PREAMBLE) || (state_d == ST_DATA)) ? ser_sym : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pre_idx_q  <= '0;
      cur_last_q <= 1'b0;
      ifg_q      <= '0;
      tx_d_q     <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_idx_q  <= pre_idx_d;
      cur_last_q <= cur_last_d;
      ifg_q      <= ifg_d;
      tx_d_q     <= tx_d_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      underrun_q <= underrun_d;
    end
  end

  assign saxis.tready = tready_c;
  assign tx_d         = tx_d_q;
  assign tx_en        = tx_en_q;
  assign tx_er        = tx_er_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_to_mii_tx.sv
// Scoreboard bench for axis_to_mii_tx: three configurations share one clock and reset;
// expected symbols are queued at stimulus time and popped by per-instance monitors.
module tb_axis_to_mii_tx;

  typedef struct packed {
    logic [3:0] d;
    logic       er;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] dat [3];
  logic       vld [3];
  logic       lst [3];
  logic       rdy [3];
  logic [3:0] txd [3];
  logic       txen [3];
  logic       txer [3];
  logic       und [3];
  logic       busy [3];

  logic [1:0] txd0;
  logic [3:0] txd1;
  logic [1:0] txd2;

  sym_t exp_q [3][$];
  int   und_cnt [3];
  int   er_cnt [3];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_first, m_last, m_cnt, m_a, m_b, m_c, u_snap, e_snap;

  axis_to_mii_tx_if ax0 ();
  axis_to_mii_tx_if ax1 ();
  axis_to_mii_tx_if ax2 ();

  assign ax0.tdata = dat[0];
  assign ax0.tvalid = vld[0];
  assign ax0.tlast = lst[0];
  assign rdy[0] = ax0.tready;
  assign ax1.tdata = dat[1];
  assign ax1.tvalid = vld[1];
  assign ax1.tlast = lst[1];
  assign rdy[1] = ax1.tready;
  assign ax2.tdata = dat[2];
  assign ax2.tvalid = vld[2];
  assign ax2.tlast = lst[2];
  assign rdy[2] = ax2.tready;

  assign txd[0] = {2'b00, txd0};
  assign txd[1] = txd1;
  assign txd[2] = {2'b00, txd2};

  axis_to_mii_tx #(.SYMBOL_WIDTH(2), .PREAMBLE_EN(1'b0), .IFG_BYTES(12), .IFG_CNT_WIDTH(8)) dut0 (
    .clock(clk), .reset(rst), .saxis(ax0), .tx_d(txd0), .tx_en(txen[0]), .tx_er(txer[0]),
    .underrun(und[0]), .busy(busy[0]));

  axis_to_mii_tx #(.SYMBOL_WIDTH(4), .PREAMBLE_EN(1'b1), .IFG_BYTES(12), .IFG_CNT_WIDTH(8)) dut1 (
    .clock(clk), .reset(rst), .saxis(ax1), .tx_d(txd1), .tx_en(txen[1]), .tx_er(txer[1]),
    .underrun(und[1]), .busy(busy[1]));

  axis_to_mii_tx #(.SYMBOL_WIDTH(2), .PREAMBLE_EN(1'b1), .IFG_BYTES(3), .IFG_CNT_WIDTH(8)) dut2 (
    .clock(clk), .reset(rst), .saxis(ax2), .tx_d(txd2), .tx_en(txen[2]), .tx_er(txer[2]),
    .underrun(und[2]), .busy(busy[2]));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name, input string detail);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  task automatic push_sym(input int i, input logic [3:0] d, input logic er);
    sym_t s;
    s.d  = d;
    s.er = er;
    exp_q[i].push_back(s);
  endtask

  task automatic push_byte(input int i, input int w, input logic [7:0] b);
    logic [7:0] sh;
    for (int k = 0; k < 8 / w; k++) begin
      sh = b >> (k * w);
      push_sym(i, (w == 2) ? {2'b00, sh[1:0]} : sh[3:0], 1'b0);
    end
  endtask

  task automatic push_pre(input int i, input int w);
    for (int k = 0; k < 7; k++) push_byte(i, w, 8'h55);
    push_byte(i, w, 8'hD5);
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic last);
    int n = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    lst[i] = last;
    @(negedge clk);
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_msg($sformatf("put%0d_timeout", i), $sformatf("byte %0h never accepted", d));
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[i] || exp_q[i].size() != 0) && n < 600);
    if (n >= 600) fail_msg($sformatf("idle%0d_timeout", i), $sformatf("busy=%0d pending=%0d", busy[i], exp_q[i].size()));
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      sym_t e;
      if (!rst) begin
        if (txen[g]) begin
          if (exp_q[g].size() == 0) begin
            fail_msg($sformatf("dut%0d_extra_symbol", g), $sformatf("got d=%0h er=%0d with nothing expected", txd[g], txer[g]));
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("dut%0d_tx_d", g), int'(txd[g]), int'(e.d));
            chk($sformatf("dut%0d_tx_er", g), int'(txer[g]), int'(e.er));
          end
        end else begin
          chk($sformatf("dut%0d_idle_tx_d", g), int'(txd[g]), 0);
          chk($sformatf("dut%0d_idle_tx_er", g), int'(txer[g]), 0);
        end
        if (und[g]) und_cnt[g]++;
        if (txer[g]) er_cnt[g]++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      dat[i] = 8'h00;
      vld[i] = 1'b0;
      lst[i] = 1'b0;
      und_cnt[i] = 0;
      er_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_tx_en", i), int'(txen[i]), 0);
      chk($sformatf("rst%0d_tx_er", i), int'(txer[i]), 0);
      chk($sformatf("rst%0d_tx_d", i), int'(txd[i]), 0);
      chk($sformatf("rst%0d_busy", i), int'(busy[i]), 0);
      chk($sformatf("rst%0d_underrun", i), int'(und[i]), 0);
    end
    chk("rst0_tready_nopre", int'(rdy[0]), 1);
    chk("rst1_tready_pre", int'(rdy[1]), 0);
    @(posedge clk);
    #1;

    // Single byte 0xB4 on RMII: symbols 0,1,3,2 then a 48-cycle gap
    push_sym(0, 4'd0, 1'b0);
    push_sym(0, 4'd1, 1'b0);
    push_sym(0, 4'd3, 1'b0);
    push_sym(0, 4'd2, 1'b0);
    m_cnt = 0; m_a = -1; m_b = 0;
    fork
      put(0, 8'hB4, 1'b1);
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (txen[0]) m_cnt++;
        if (c > 0 && !busy[0] && m_a < 0) m_a = c;
        if (busy[0] && !txen[0] && rdy[0]) m_b++;
      end
    join
    chk("t1_tx_en_cycles", m_cnt, 4);
    chk("t1_busy_fall_cycle", m_a, 53);
    chk("t1_tready_in_ifg", m_b, 0);
    wait_idle(0);

    // MII with preamble: 0x12,0x34 behind 15x5 and one D
    push_pre(1, 4);
    push_byte(1, 4, 8'h12);
    push_byte(1, 4, 8'h34);
    m_first = -1; m_last = -1; m_cnt = 0;
    fork
      begin
        put(1, 8'h12, 1'b0);
        put(1, 8'h34, 1'b1);
      end
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (txen[1]) begin
          m_cnt++;
          if (m_first < 0) m_first = c;
          m_last = c;
        end
      end
    join
    chk("t2_first_tx_en", m_first, 1);
    chk("t2_tx_en_cycles", m_cnt, 20);
    chk("t2_tx_en_span", m_last - m_first + 1, 20);
    wait_idle(1);

    // RMII back-to-back stream 0x00..0x3F
    for (int b = 0; b < 64; b++) push_byte(0, 2, 8'(b));
    m_first = -1; m_last = -1; m_cnt = 0; m_a = 0; m_b = 0; m_c = 0;
    fork
      for (int b = 0; b < 64; b++) put(0, 8'(b), (b == 63));
      for (int c = 0; c < 330; c++) begin
        @(negedge clk);
        if (txen[0]) begin
          m_cnt++;
          if (m_first < 0) m_first = c;
          m_last = c;
        end
        if (busy[0] && rdy[0]) begin
          m_a++;
          if (c % 4 != 0) m_b++;
          if (!txen[0]) m_c++;
        end
      end
    join
    chk("t3_tx_en_cycles", m_cnt, 256);
    chk("t3_tx_en_span", m_last - m_first + 1, 256);
    chk("t3_tready_pulses", m_a, 63);
    chk("t3_tready_off_grid", m_b, 0);
    chk("t3_tready_in_ifg", m_c, 0);
    wait_idle(0);

    // MII underrun after the fourth byte of a ten-byte frame
    u_snap = und_cnt[1];
    e_snap = er_cnt[1];
    push_pre(1, 4);
    for (int b = 0; b < 4; b++) push_byte(1, 4, 8'hA0 + 8'(b));
    push_sym(1, 4'd0, 1'b1);
    push_sym(1, 4'd0, 1'b1);
    for (int b = 0; b < 4; b++) put(1, 8'hA0 + 8'(b), 1'b0);
    m_a = 0;
    while (!und[1] && m_a < 20) begin
      @(negedge clk);
      m_a++;
    end
    if (m_a >= 20) fail_msg("t4_underrun_seen", "no underrun pulse within 20 cycles");
    for (int b = 4; b < 10; b++) put(1, 8'hA0 + 8'(b), (b == 9));
    m_a = -1; m_cnt = 0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (txen[1]) m_cnt++;
      if (!busy[1] && m_a < 0) m_a = c;
    end
    chk("t4_ifg_busy_fall", m_a, 25);
    chk("t4_tx_en_after_discard", m_cnt, 0);
    chk("t4_underrun_pulses", und_cnt[1] - u_snap, 1);
    chk("t4_tx_er_cycles", er_cnt[1] - e_snap, 2);
    @(posedge clk);
    #1;
    push_pre(1, 4);
    push_byte(1, 4, 8'h5A);
    put(1, 8'h5A, 1'b1);
    wait_idle(1);

    // Reset pulse in the middle of a payload byte
    push_byte(0, 2, 8'hA5);
    push_byte(0, 2, 8'h3C);
    put(0, 8'hA5, 1'b0);
    put(0, 8'h3C, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q[0].delete();
    @(negedge clk);
    chk("t5_tx_en", int'(txen[0]), 0);
    chk("t5_tx_er", int'(txer[0]), 0);
    chk("t5_tx_d", int'(txd[0]), 0);
    chk("t5_busy", int'(busy[0]), 0);
    chk("t5_tready", int'(rdy[0]), 1);
    @(posedge clk);
    #1;
    push_byte(0, 2, 8'h5A);
    put(0, 8'h5A, 1'b1);
    wait_idle(0);

    // Two RMII frames offered back-to-back with a 3-byte gap
    push_pre(2, 2);
    push_byte(2, 2, 8'h11);
    push_byte(2, 2, 8'h22);
    push_pre(2, 2);
    push_byte(2, 2, 8'h33);
    m_a = 0; m_b = 0;
    fork
      begin
        put(2, 8'h11, 1'b0);
        put(2, 8'h22, 1'b1);
        put(2, 8'h33, 1'b1);
      end
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        case (m_a)
          0: if (txen[2]) m_a = 1;
          1: if (!txen[2]) begin m_a = 2; m_b = 1; end
          2: if (txen[2]) m_a = 3; else m_b++;
          default: ;
        endcase
      end
    join
    chk("t6_second_frame_seen", m_a, 3);
    chk("t6_gap_cycles", m_b, 12);
    wait_idle(2);

    for (int i = 0; i < 3; i++) chk($sformatf("dut%0d_pending_symbols", i), exp_q[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
